// File: rtl/loader_pkg.sv
// ---------------------------------------------------------------
// loader_pkg: shared states and constants for the program loader
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package loader_pkg;

   localparam int         LEN_W         = 16;
   localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

   typedef enum logic [2:0] {
      ST_SYNC   = 3'd0,
      ST_LEN_LO = 3'd1,
      ST_LEN_HI = 3'd2,
      ST_DATA   = 3'd3,
      ST_CHECK  = 3'd4,
      ST_DONE   = 3'd5,
      ST_ERROR  = 3'd6
   } state_t;

endpackage

`default_nettype wire

// File: rtl/byte_packer.sv
// ---------------------------------------------------------------
// byte_packer: 8-to-32 little-endian word assembler, one-cycle word strobe
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module byte_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_clear,
   input  logic        i_valid,
   input  logic [7:0]  i_data,
   output logic [1:0]  o_idx,
   output logic        o_word_valid,
   output logic [31:0] o_word
);

   logic [1:0]  r_idx;
   logic        r_word_valid;
   logic [31:0] r_word;

   // Bytes enter at the top and shift down, so byte 0 ends up in [7:0].
   always_ff @(posedge clk) begin
      if (rst) begin
         r_idx        <= 2'd0;
         r_word_valid <= 1'b0;
         r_word       <= 32'd0;
      end else begin
         r_word_valid <= 1'b0;
         if (i_clear) begin
            r_idx <= 2'd0;
         end else if (i_valid) begin
            r_word       <= {i_data, r_word[31:8]};
            r_idx        <= r_idx + 2'd1;
            r_word_valid <= (r_idx == 2'd3);
         end
      end
   end

   assign o_idx        = r_idx;
   assign o_word_valid = r_word_valid;
   assign o_word       = r_word;

endmodule

`default_nettype wire

// File: rtl/prog_loader.sv
// ---------------------------------------------------------------
// prog_loader: boot loader writing a checksummed byte frame into imem
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module prog_loader
   import loader_pkg::*;
#(
   parameter int         ADDR_WIDTH = 8,
   parameter int         MAX_WORDS  = 2**ADDR_WIDTH,
   parameter logic [7:0] SYNC_BYTE  = SYNC_BYTE_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic                  rx_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  core_rst_n,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   state_t                  r_state;
   state_t                  w_next;
   logic                    r_rx_ready;
   logic [7:0]              r_len_lo;
   logic [LEN_W-1:0]        r_words_left;
   logic [7:0]              r_chk;
   logic [ADDR_WIDTH-1:0]   r_addr;
   logic                    r_core_rst_n;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_error;

   logic                    w_accept;
   logic                    w_is_sync;
   logic [LEN_W-1:0]        w_len;
   logic                    w_len_over;
   logic                    w_pack_valid;
   logic                    w_pack_clear;
   logic                    w_word_last;
   logic [1:0]              w_idx;
   logic                    w_word_valid;
   logic [31:0]             w_word;

   assign w_accept     = rx_valid && r_rx_ready;
   assign w_is_sync    = (rx_data == SYNC_BYTE);
   assign w_len        = {rx_data, r_len_lo};
   assign w_len_over   = ({{(32-LEN_W){1'b0}}, w_len} > MAX_WORDS);
   assign w_pack_valid = w_accept && (r_state == ST_DATA);
   assign w_pack_clear = w_accept && (r_state == ST_LEN_HI);
   // The FSM leaves DATA on the 4th byte of the last word, one cycle before
   // the packer strobes that word, so a back-to-back CHK byte is not missed.
   assign w_word_last  = w_pack_valid && (w_idx == 2'd3) &&
                         (r_words_left == {{(LEN_W-1){1'b0}}, 1'b1});

   byte_packer u_packer (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (w_pack_clear),
      .i_valid      (w_pack_valid),
      .i_data       (rx_data),
      .o_idx        (w_idx),
      .o_word_valid (w_word_valid),
      .o_word       (w_word)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_SYNC: begin
            if (w_accept && w_is_sync) w_next = ST_LEN_LO;
         end
         ST_LEN_LO: begin
            if (w_accept) w_next = ST_LEN_HI;
         end
         ST_LEN_HI: begin
            if (w_accept) begin
               if (w_len_over)                 w_next = ST_ERROR;
               else if (w_len == {LEN_W{1'b0}}) w_next = ST_CHECK;
               else                             w_next = ST_DATA;
            end
         end
         ST_DATA: begin
            if (w_word_last) w_next = ST_CHECK;
         end
         ST_CHECK: begin
            if (w_accept) w_next = (rx_data == r_chk) ? ST_DONE : ST_ERROR;
         end
         ST_DONE, ST_ERROR: begin
            if (w_accept && w_is_sync) w_next = ST_LEN_LO;
         end
         default: w_next = ST_SYNC;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_SYNC;
         r_rx_ready   <= 1'b0;
         r_len_lo     <= 8'd0;
         r_words_left <= {LEN_W{1'b0}};
         r_chk        <= 8'd0;
         r_addr       <= {ADDR_WIDTH{1'b0}};
         r_core_rst_n <= 1'b0;
         r_busy       <= 1'b0;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
      end else begin
         r_state      <= w_next;
         r_rx_ready   <= 1'b1;
         // Status flags are registered from the next state so they line up with it.
         r_core_rst_n <= (w_next == ST_DONE);
         r_done       <= (w_next == ST_DONE);
         r_error      <= (w_next == ST_ERROR);
         r_busy       <= (w_next == ST_LEN_LO) || (w_next == ST_LEN_HI) ||
                         (w_next == ST_DATA)   || (w_next == ST_CHECK);
         if (w_word_valid) r_addr <= r_addr + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
         if (w_accept) begin
            case (r_state)
               ST_SYNC, ST_DONE, ST_ERROR: begin
                  if (w_is_sync) r_chk <= 8'd0;
               end
               ST_LEN_LO: begin
                  r_len_lo <= rx_data;
                  r_chk    <= r_chk ^ rx_data;
               end
               ST_LEN_HI: begin
                  r_chk        <= r_chk ^ rx_data;
                  r_words_left <= w_len;
                  r_addr       <= {ADDR_WIDTH{1'b0}};
               end
               ST_DATA: begin
                  r_chk <= r_chk ^ rx_data;
                  if (w_idx == 2'd3) r_words_left <= r_words_left - {{(LEN_W-1){1'b0}}, 1'b1};
               end
               default: ;
            endcase
         end
      end
   end

   assign rx_ready   = r_rx_ready;
   assign imem_we    = w_word_valid;
   assign imem_addr  = r_addr;
   assign imem_wdata = w_word;
   assign core_rst_n = r_core_rst_n;
   assign busy       = r_busy;
   assign done       = r_done;
   assign error      = r_error;

endmodule

`default_nettype wire

// File: tb/tb_prog_loader.sv
// ---------------------------------------------------------------
// tb_prog_loader: randomized frame stimulus against a frame-level model
// Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module tb_prog_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic [7:0]  rx_data, b_rx_data;
   logic        rx_valid, b_rx_valid;
   logic        rx_ready, b_rx_ready;
   logic        imem_we, b_imem_we;
   logic [7:0]  imem_addr;
   logic [1:0]  b_imem_addr;
   logic [31:0] imem_wdata, b_imem_wdata;
   logic        core_rst_n, b_core_rst_n;
   logic        busy, b_busy, done, b_done, error, b_error;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   logic [7:0]  wa_q[$];
   logic [31:0] wd_q[$];
   int          wt_q[$];
   logic [1:0]  b_wa_q[$];
   logic [31:0] b_wd_q[$];
   logic [31:0] exp_words[$];
   logic [7:0]  frame_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   prog_loader #(.ADDR_WIDTH(8)) dut_a (
      .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .core_rst_n(core_rst_n), .busy(busy), .done(done), .error(error));

   prog_loader #(.ADDR_WIDTH(2)) dut_b (
      .clk(clk), .rst(rst), .rx_data(b_rx_data), .rx_valid(b_rx_valid), .rx_ready(b_rx_ready),
      .imem_we(b_imem_we), .imem_addr(b_imem_addr), .imem_wdata(b_imem_wdata),
      .core_rst_n(b_core_rst_n), .busy(b_busy), .done(b_done), .error(b_error));

   always @(negedge clk) begin
      if (imem_we === 1'b1) begin
         wa_q.push_back(imem_addr); wd_q.push_back(imem_wdata); wt_q.push_back(cyc);
      end
      if (b_imem_we === 1'b1) begin
         b_wa_q.push_back(b_imem_addr); b_wd_q.push_back(b_imem_wdata);
      end
   end

   task automatic clear_log();
      wa_q.delete(); wd_q.delete(); wt_q.delete(); b_wa_q.delete(); b_wd_q.delete();
   endtask

   // Frame model: SYNC, 16-bit LE length, LE payload words, XOR checksum.
   task automatic build_frame(input bit corrupt);
      int         n;
      logic [7:0] chk, bt;
      logic [31:0] w;
      n = exp_words.size();
      frame_q.delete();
      frame_q.push_back(8'hA5);
      frame_q.push_back(n[7:0]);
      frame_q.push_back(n[15:8]);
      chk = n[7:0] ^ n[15:8];
      for (int i = 0; i < n; i++) begin
         w = exp_words[i];
         for (int k = 0; k < 4; k++) begin
            bt = w[8*k +: 8];
            frame_q.push_back(bt);
            chk = chk ^ bt;
         end
      end
      if (corrupt) chk = chk ^ 8'h01;
      frame_q.push_back(chk);
   endtask

   task automatic rand_words(input int n);
      exp_words.delete();
      for (int i = 0; i < n; i++) exp_words.push_back($urandom);
   endtask

   task automatic send_byte(input bit to_b, input logic [7:0] bt, input int gap);
      if (to_b) begin b_rx_data = bt; b_rx_valid = 1'b1; end
      else      begin rx_data   = bt; rx_valid   = 1'b1; end
      @(posedge clk); #1;
      if (gap > 0) begin
         rx_valid = 1'b0; b_rx_valid = 1'b0;
         rx_data = 8'(($urandom % 2) != 0 ? 8'hA5 : 8'h3C);
         repeat (gap) begin @(posedge clk); #1; end
      end
   endtask

   // The last byte is never followed by a gap so flags are checked right after CHK.
   task automatic send_frame(input bit to_b, input int maxgap);
      int g;
      for (int i = 0; i < frame_q.size(); i++) begin
         g = (maxgap > 0 && i != frame_q.size() - 1) ? int'($urandom_range(1, maxgap)) : 0;
         send_byte(to_b, frame_q[i], g);
      end
      rx_valid = 1'b0; b_rx_valid = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1; rx_valid = 1'b0; b_rx_valid = 1'b0; rx_data = 8'h00; b_rx_data = 8'h00;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         total++;
         if ({rx_ready, core_rst_n, busy, imem_we, done, error} !== 6'b0) begin
            bad++;
            $display("FAIL reset_hold: got rdy,crst,busy,we,done,err=%b want 000000",
                     {rx_ready, core_rst_n, busy, imem_we, done, error});
         end
      end
      rst = 1'b0;
      @(posedge clk); #1;
      total++;
      if ({rx_ready, core_rst_n, busy, done, error} !== 5'b10000) begin
         bad++;
         $display("FAIL reset_release: got rdy,crst,busy,done,err=%b want 10000",
                  {rx_ready, core_rst_n, busy, done, error});
      end
      total++;
      if (imem_addr !== 8'd0 || imem_wdata !== 32'd0) begin
         bad++;
         $display("FAIL reset_imem: got addr=%h data=%h want 0/0", imem_addr, imem_wdata);
      end
   endtask

   task automatic test_nominal();
      exp_words.delete();
      exp_words.push_back(32'h00500093);
      exp_words.push_back(32'h00A00113);
      build_frame(1'b0);
      clear_log();
      send_frame(1'b0, 0);
      total++;
      if ({done, core_rst_n, error, busy} !== 4'b1100) begin
         bad++;
         $display("FAIL nominal_flags: got done,crst,err,busy=%b want 1100", {done, core_rst_n, error, busy});
      end
      total++;
      if (wa_q.size() != 2) begin
         bad++; $display("FAIL nominal_count: got %0d writes want 2", wa_q.size());
      end
      for (int i = 0; i < wa_q.size() && i < 2; i++) begin
         total++;
         if (wa_q[i] !== 8'(i) || wd_q[i] !== exp_words[i]) begin
            bad++;
            $display("FAIL nominal_write%0d: got %h@%h want %h@%h", i, wd_q[i], wa_q[i], exp_words[i], 8'(i));
         end
      end
      if (wt_q.size() == 2) begin
         total++;
         if (wt_q[1] - wt_q[0] != 4) begin
            bad++; $display("FAIL nominal_spacing: got %0d cycles want 4", wt_q[1] - wt_q[0]);
         end
      end
   endtask

   task automatic test_bad_chk();
      build_frame(1'b1);
      clear_log();
      send_frame(1'b0, 0);
      total++;
      if ({error, done, core_rst_n, busy} !== 4'b1000) begin
         bad++;
         $display("FAIL badchk_flags: got err,done,crst,busy=%b want 1000", {error, done, core_rst_n, busy});
      end
      total++;
      if (wa_q.size() != 2 || wd_q[0] !== exp_words[0] || wd_q[wd_q.size()-1] !== exp_words[1]) begin
         bad++; $display("FAIL badchk_writes: got %0d writes want 2 matching words", wa_q.size());
      end
      build_frame(1'b0);
      send_frame(1'b0, 0);
      total++;
      if ({done, core_rst_n, error} !== 3'b110) begin
         bad++; $display("FAIL badchk_recover: got done,crst,err=%b want 110", {done, core_rst_n, error});
      end
   endtask

   task automatic test_oversize();
      clear_log();
      send_byte(1'b1, 8'hA5, 0);
      send_byte(1'b1, 8'h05, 0);
      send_byte(1'b1, 8'h00, 0);
      b_rx_valid = 1'b0;
      total++;
      if ({b_error, b_busy, b_done} !== 3'b100) begin
         bad++; $display("FAIL oversize_flags: got err,busy,done=%b want 100", {b_error, b_busy, b_done});
      end
      for (int i = 0; i < 4; i++) send_byte(1'b1, 8'(8'h11 * (i + 1)), 0);
      b_rx_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (b_wa_q.size() != 0 || b_error !== 1'b1) begin
         bad++; $display("FAIL oversize_nowrite: got %0d writes err=%b want 0 writes err=1", b_wa_q.size(), b_error);
      end
      rand_words(4);
      build_frame(1'b0);
      send_frame(1'b1, 2);
      total++;
      if ({b_done, b_core_rst_n, b_error} !== 3'b110) begin
         bad++; $display("FAIL maxlen_flags: got done,crst,err=%b want 110", {b_done, b_core_rst_n, b_error});
      end
      total++;
      if (b_wa_q.size() != 4) begin
         bad++; $display("FAIL maxlen_count: got %0d writes want 4", b_wa_q.size());
      end
      for (int i = 0; i < b_wa_q.size() && i < 4; i++) begin
         total++;
         if (b_wa_q[i] !== 2'(i) || b_wd_q[i] !== exp_words[i]) begin
            bad++; $display("FAIL maxlen_write%0d: got %h@%h want %h@%h", i, b_wd_q[i], b_wa_q[i], exp_words[i], 2'(i));
         end
      end
   endtask

   task automatic test_gapped_junk();
      exp_words.delete();
      exp_words.push_back(32'h00500093);
      exp_words.push_back(32'h00A00113);
      build_frame(1'b0);
      clear_log();
      send_byte(1'b0, 8'h00, int'($urandom_range(1, 5)));
      send_byte(1'b0, 8'hFF, int'($urandom_range(1, 5)));
      send_frame(1'b0, 5);
      total++;
      if ({done, core_rst_n, error} !== 3'b110) begin
         bad++; $display("FAIL gapped_flags: got done,crst,err=%b want 110", {done, core_rst_n, error});
      end
      total++;
      if (wa_q.size() != 2 || wa_q[0] !== 8'd0 || wd_q[0] !== exp_words[0] ||
          wa_q[wa_q.size()-1] !== 8'd1 || wd_q[wd_q.size()-1] !== exp_words[1]) begin
         bad++; $display("FAIL gapped_writes: got %0d writes want 2 at addr 0,1", wa_q.size());
      end
   endtask

   task automatic test_zero_len();
      exp_words.delete();
      build_frame(1'b0);
      clear_log();
      send_frame(1'b0, 0);
      total++;
      if ({done, core_rst_n, error} !== 3'b110 || wa_q.size() != 0) begin
         bad++; $display("FAIL zero_len: got done,crst,err=%b writes=%0d want 110 writes=0",
                         {done, core_rst_n, error}, wa_q.size());
      end
   endtask

   task automatic test_reload();
      total++;
      if (core_rst_n !== 1'b1) begin
         bad++; $display("FAIL reload_pre: got crst=%b want 1", core_rst_n);
      end
      rand_words(3);
      build_frame(1'b0);
      clear_log();
      send_byte(1'b0, frame_q.pop_front(), 0);
      rx_valid = 1'b0;
      total++;
      if ({core_rst_n, busy, done} !== 3'b010) begin
         bad++; $display("FAIL reload_drop: got crst,busy,done=%b want 010", {core_rst_n, busy, done});
      end
      send_frame(1'b0, 1);
      total++;
      if (done !== 1'b1 || wa_q.size() != 3 || wd_q[wd_q.size()-1] !== exp_words[2]) begin
         bad++; $display("FAIL reload_load: got done=%b writes=%0d want done=1 writes=3", done, wa_q.size());
      end
   endtask

   task automatic test_mid_rst();
      rand_words(4);
      build_frame(1'b0);
      for (int i = 0; i < 9; i++) send_byte(1'b0, frame_q[i], 0);
      rx_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      total++;
      if ({busy, done, error, core_rst_n, imem_we, rx_ready} !== 6'b0 ||
          imem_addr !== 8'd0 || imem_wdata !== 32'd0) begin
         bad++; $display("FAIL midrst_state: got busy,done,err,crst,we,rdy=%b addr=%h data=%h want all 0",
                         {busy, done, error, core_rst_n, imem_we, rx_ready}, imem_addr, imem_wdata);
      end
      rst = 1'b0;
      @(posedge clk); #1;
      rand_words(3);
      build_frame(1'b0);
      clear_log();
      send_frame(1'b0, 0);
      total++;
      if (done !== 1'b1 || wa_q.size() != 3) begin
         bad++; $display("FAIL midrst_reload: got done=%b writes=%0d want 1/3", done, wa_q.size());
      end
      for (int i = 0; i < wa_q.size() && i < 3; i++) begin
         total++;
         if (wa_q[i] !== 8'(i) || wd_q[i] !== exp_words[i]) begin
            bad++; $display("FAIL midrst_write%0d: got %h@%h want %h@%h", i, wd_q[i], wa_q[i], exp_words[i], 8'(i));
         end
      end
   endtask

   task automatic test_random_frames();
      int n, maxgap, errs;
      bit corrupt;
      for (int f = 0; f < 8; f++) begin
         n       = int'($urandom_range(1, 12));
         corrupt = ($urandom % 3) == 0;
         maxgap  = (f % 2 == 0) ? 0 : int'($urandom_range(1, 3));
         rand_words(n);
         build_frame(corrupt);
         clear_log();
         send_frame(1'b0, maxgap);
         total++;
         if ({done, error, core_rst_n} !== {!corrupt, corrupt, !corrupt}) begin
            bad++; $display("FAIL rand%0d_flags: got done,err,crst=%b want %b", f,
                            {done, error, core_rst_n}, {!corrupt, corrupt, !corrupt});
         end
         errs = 0;
         if (wa_q.size() != n) errs++;
         for (int i = 0; i < wa_q.size() && i < n; i++)
            if (wa_q[i] !== 8'(i) || wd_q[i] !== exp_words[i]) errs++;
         if (maxgap == 0)
            for (int i = 1; i < wt_q.size(); i++)
               if (wt_q[i] - wt_q[i-1] != 4) errs++;
         total++;
         if (errs != 0) begin
            bad++; $display("FAIL rand%0d_writes: got %0d writes, %0d bad entries want %0d clean", f, wa_q.size(), errs, n);
         end
      end
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_bad_chk();
      test_oversize();
      test_gapped_junk();
      test_zero_len();
      test_reload();
      test_mid_rst();
      test_random_frames();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
